// File: rtl/multi_clkgen_pkg.sv
// Shared types and reset-default channel configuration for multi_clkgen.
package multi_clkgen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPhase,
    StHigh,
    StLow
  } chan_state_e;

  // Reset configuration: no start delay, divide-by-2.
  localparam int unsigned DefPhase = 0;
  localparam int unsigned DefTon   = 1;
  localparam int unsigned DefToff  = 1;

  // Width of a channel index, never narrower than one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkgen_chan.sv
// One clock-generator channel: shadow/active config, state machine and segment counter.
module clkgen_chan
  import multi_clkgen_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_phase,
  input  logic [CNT_W-1:0] i_ton,
  input  logic [CNT_W-1:0] i_toff,
  output logic             o_clk,
  output logic             o_rise,
  output logic             o_pend
);

  chan_state_e      r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [CNT_W-1:0] r_sh_phase, r_sh_ton, r_sh_toff;
  // Phase is only consumed when leaving IDLE, where active always equals shadow,
  // so only ton/toff need an active copy.
  logic [CNT_W-1:0] r_ac_ton, r_ac_toff, w_ac_ton_d, w_ac_toff_d;
  logic             r_pend, w_pend_d;
  logic             r_clk, w_clk_d;
  logic             r_rise, w_rise_d;
  logic             w_start, w_use_sh, w_last;
  logic [CNT_W-1:0] w_ton_eff, w_toff_eff;

  // Shadow configuration written by the host.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sh_phase <= CNT_W'(DefPhase);
      r_sh_ton   <= CNT_W'(DefTon);
      r_sh_toff  <= CNT_W'(DefToff);
    end else if (i_wr) begin
      r_sh_phase <= i_phase;
      r_sh_ton   <= i_ton;
      r_sh_toff  <= i_toff;
    end
  end

  // Next-state logic; w_start marks a period boundary (entry into HIGH).
  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_ac_ton_d  = r_ac_ton;
    w_ac_toff_d = r_ac_toff;
    w_pend_d    = r_pend;
    w_start     = 1'b0;
    w_last      = (r_cnt <= CNT_W'(1));
    w_use_sh    = (r_state == StIdle) || r_pend;
    w_ton_eff   = w_use_sh ? r_sh_ton : r_ac_ton;
    w_toff_eff  = w_use_sh ? r_sh_toff : r_ac_toff;

    if (!i_en) begin
      if (r_state != StIdle) begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end else begin
        w_ac_ton_d  = r_sh_ton;
        w_ac_toff_d = r_sh_toff;
        w_pend_d    = 1'b0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          w_ac_ton_d  = r_sh_ton;
          w_ac_toff_d = r_sh_toff;
          w_pend_d    = 1'b0;
          if (r_sh_phase == '0) begin
            w_start = 1'b1;
          end else begin
            w_state_d = StPhase;
            w_cnt_d   = r_sh_phase;
          end
        end
        StPhase, StLow: begin
          if (w_last) w_start = 1'b1;
          else        w_cnt_d = r_cnt - CNT_W'(1);
        end
        StHigh: begin
          if (w_last) begin
            if (r_ac_toff != '0) begin
              w_state_d = StLow;
              w_cnt_d   = r_ac_toff;
            end else begin
              w_start = 1'b1;
            end
          end else begin
            w_cnt_d = r_cnt - CNT_W'(1);
          end
        end
      endcase
    end

    // Period boundary: apply pending config; ton=0 degrades to a low segment.
    if (w_start) begin
      w_ac_ton_d  = w_ton_eff;
      w_ac_toff_d = w_toff_eff;
      w_pend_d    = 1'b0;
      if (w_ton_eff != '0) begin
        w_state_d = StHigh;
        w_cnt_d   = w_ton_eff;
      end else begin
        w_state_d = StLow;
        w_cnt_d   = w_toff_eff;
      end
    end

    // A write always leaves the new value pending, even on an apply edge.
    if (i_wr) w_pend_d = 1'b1;

    w_clk_d  = (w_state_d == StHigh);
    w_rise_d = w_clk_d && !r_clk;
  end

  // Channel state and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_ac_ton  <= CNT_W'(DefTon);
      r_ac_toff <= CNT_W'(DefToff);
      r_pend    <= 1'b0;
      r_clk     <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_ac_ton  <= w_ac_ton_d;
      r_ac_toff <= w_ac_toff_d;
      r_pend    <= w_pend_d;
      r_clk     <= w_clk_d;
      r_rise    <= w_rise_d;
    end
  end

  assign o_clk  = r_clk;
  assign o_rise = r_rise;
  assign o_pend = r_pend;

endmodule

// File: rtl/multi_clkgen.sv
// Multi-channel programmable clock generator: NCH independent clkgen_chan instances.
module multi_clkgen
  import multi_clkgen_pkg::*;
#(
  parameter  int unsigned NCH   = 4,
  parameter  int unsigned CNT_W = 8,
  localparam int unsigned CH_W  = ch_width(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             cfg_wr,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_phase,
  input  logic [CNT_W-1:0] cfg_ton,
  input  logic [CNT_W-1:0] cfg_toff,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   rise_pls,
  output logic [NCH-1:0]   cfg_pend
);

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logic w_wr;
    // Indices >= NCH match no channel, so such writes are dropped.
    assign w_wr = cfg_wr && (cfg_ch == CH_W'(g));

    clkgen_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_en   (en[g]),
      .i_wr   (w_wr),
      .i_phase(cfg_phase),
      .i_ton  (cfg_ton),
      .i_toff (cfg_toff),
      .o_clk  (clk_out[g]),
      .o_rise (rise_pls[g]),
      .o_pend (cfg_pend[g])
    );
  end

endmodule

// File: tb/tb_multi_clkgen.sv
// Self-checking bench for multi_clkgen: segment-level reference model plus directed literals.
module tb_multi_clkgen;

  localparam int NCh = 4;
  localparam int SegIdle  = 0;
  localparam int SegDelay = 1;
  localparam int SegHi    = 2;
  localparam int SegLo    = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCh-1:0] en;
  logic           cfg_wr;
  logic [1:0]     cfg_ch;
  logic [7:0]     cfg_phase, cfg_ton, cfg_toff;
  logic [NCh-1:0] clk_out, rise_pls, cfg_pend;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_on   = 1'b0;

  // Reference model: each channel is a sequence of timed segments.
  int m_sh_ph [NCh];
  int m_sh_on [NCh];
  int m_sh_off[NCh];
  int m_ac_on [NCh];
  int m_ac_off[NCh];
  int m_seg   [NCh];
  int m_left  [NCh];
  bit m_pend  [NCh];
  bit m_out   [NCh];
  bit m_rise  [NCh];

  multi_clkgen #(
    .NCH  (4),
    .CNT_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_phase(cfg_phase),
    .cfg_ton  (cfg_ton),
    .cfg_toff (cfg_toff),
    .clk_out  (clk_out),
    .rise_pls (rise_pls),
    .cfg_pend (cfg_pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCh; i++) begin
      m_sh_ph[i] = 0; m_sh_on[i] = 1; m_sh_off[i] = 1;
      m_ac_on[i] = 1; m_ac_off[i] = 1;
      m_seg[i] = SegIdle; m_left[i] = 0;
      m_pend[i] = 1'b0; m_out[i] = 1'b0; m_rise[i] = 1'b0;
    end
  endtask

  // New period: pending config takes effect; a zero-length segment lasts one cycle.
  task automatic start_period(input int i, input int on, input int off);
    if (m_pend[i]) begin
      m_ac_on[i] = on; m_ac_off[i] = off; m_pend[i] = 1'b0;
    end
    if (m_ac_on[i] > 0) begin
      m_seg[i] = SegHi; m_left[i] = m_ac_on[i];
    end else begin
      m_seg[i] = SegLo; m_left[i] = (m_ac_off[i] > 0) ? m_ac_off[i] : 1;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NCh; i++) begin
      bit wr, prev;
      int o_ph, o_on, o_off;
      wr = cfg_wr && (int'(cfg_ch) == i);
      o_ph = m_sh_ph[i]; o_on = m_sh_on[i]; o_off = m_sh_off[i];
      prev = m_out[i];
      if (!en[i]) begin
        if (m_seg[i] != SegIdle) begin
          m_seg[i] = SegIdle; m_left[i] = 0;
        end else begin
          m_ac_on[i] = o_on; m_ac_off[i] = o_off; m_pend[i] = 1'b0;
        end
      end else if (m_seg[i] == SegIdle) begin
        m_ac_on[i] = o_on; m_ac_off[i] = o_off; m_pend[i] = 1'b0;
        if (o_ph == 0) start_period(i, o_on, o_off);
        else begin m_seg[i] = SegDelay; m_left[i] = o_ph; end
      end else begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          if (m_seg[i] == SegHi && m_ac_off[i] > 0) begin
            m_seg[i] = SegLo; m_left[i] = m_ac_off[i];
          end else begin
            start_period(i, o_on, o_off);
          end
        end
      end
      m_out[i]  = (m_seg[i] == SegHi);
      m_rise[i] = m_out[i] && !prev;
      if (wr) begin
        m_sh_ph[i] = int'(cfg_phase); m_sh_on[i] = int'(cfg_ton); m_sh_off[i] = int'(cfg_toff);
        m_pend[i] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #2;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic write(input int ch, input int ph, input int on, input int off);
    cfg_wr = 1'b1; cfg_ch = 2'(ch);
    cfg_phase = 8'(ph); cfg_ton = 8'(on); cfg_toff = 8'(off);
  endtask

  function automatic logic [7:0] rnd_cnt();
    return ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
  endfunction

  // Compare DUT against the model on every falling edge outside reset.
  initial begin
    logic [NCh-1:0] e_clk, e_rise, e_pend;
    forever begin
      @(negedge clk);
      if (!rst && chk_on) begin
        for (int i = 0; i < NCh; i++) begin
          e_clk[i] = m_out[i]; e_rise[i] = m_rise[i]; e_pend[i] = m_pend[i];
        end
        check("model_clk_out", 32'(clk_out), 32'(e_clk));
        check("model_rise_pls", 32'(rise_pls), 32'(e_rise));
        check("model_cfg_pend", 32'(cfg_pend), 32'(e_pend));
      end
    end
  end

  initial begin
    int ones;
    rst = 1'b1; en = '0; cfg_wr = 1'b0; cfg_ch = '0;
    cfg_phase = '0; cfg_ton = '0; cfg_toff = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("reset_clk_out", 32'(clk_out), 32'h0);
    check("reset_cfg_pend", 32'(cfg_pend), 32'h0);
    en = 4'b0001; rst = 1'b0; cyc = 0; chk_on = 1'b1;

    // Defaults: divide-by-2 from cycle 1.
    for (int c = 1; c <= 6; c++) begin
      goto(c);
      check("ch0_div2_clk", 32'(clk_out[0]), 32'(c % 2));
      check("ch0_div2_rise", 32'(rise_pls[0]), 32'(c % 2));
    end
    goto(7);  write(1, 7, 5, 5);
    goto(8);  cfg_wr = 1'b0; check("ch1_pend_set", 32'(cfg_pend[1]), 32'h1);
    goto(9);  check("ch1_pend_idle_clr", 32'(cfg_pend[1]), 32'h0);
    goto(10); en[1] = 1'b1;
    goto(17); check("ch1_phase_low", 32'(clk_out[1]), 32'h0);
    goto(18); check("ch1_first_rise", 32'(clk_out[1]), 32'h1);
              check("ch1_first_rise_pls", 32'(rise_pls[1]), 32'h1);
    goto(19); check("ch1_rise_one_cycle", 32'(rise_pls[1]), 32'h0);
    goto(22); check("ch1_high_last", 32'(clk_out[1]), 32'h1);
    goto(23); check("ch1_low_first", 32'(clk_out[1]), 32'h0);
    goto(27); check("ch1_low_last", 32'(clk_out[1]), 32'h0);
    goto(28); check("ch1_period10", 32'(clk_out[1]), 32'h1);

    // Retune ch2 mid-HIGH.
    goto(30); write(2, 0, 3, 2);
    goto(31); cfg_wr = 1'b0;
    goto(32); en[2] = 1'b1;
    goto(38); write(2, 0, 1, 4);
    goto(39); cfg_wr = 1'b0; check("ch2_pend_mid_high", 32'(cfg_pend[2]), 32'h1);
    goto(40); check("ch2_old_high_kept", 32'(clk_out[2]), 32'h1);
    goto(41); check("ch2_old_low", 32'(clk_out[2]), 32'h0);
    goto(42); check("ch2_pend_held", 32'(cfg_pend[2]), 32'h1);
    goto(43); check("ch2_new_rise", 32'(clk_out[2]), 32'h1);
              check("ch2_pend_applied", 32'(cfg_pend[2]), 32'h0);
    goto(44); check("ch2_new_ton1", 32'(clk_out[2]), 32'h0);
    goto(47); check("ch2_new_toff4", 32'(clk_out[2]), 32'h0);
    goto(48); check("ch2_new_period", 32'(clk_out[2]), 32'h1);

    // ch1 disable mid-HIGH and re-enable.
    goto(49); check("ch1_high_before_dis", 32'(clk_out[1]), 32'h1); en[1] = 1'b0;
    goto(50); check("ch1_dis_low", 32'(clk_out[1]), 32'h0);
    goto(55); en[1] = 1'b1;
    goto(60); write(3, 0, 0, 4);
    goto(61); cfg_wr = 1'b0;
    goto(62); check("ch1_reen_phase", 32'(clk_out[1]), 32'h0); en[3] = 1'b1;
    goto(63); check("ch1_reen_rise", 32'(rise_pls[1]), 32'h1);

    // ton=0 holds low; then toff=0 holds high after a single rise.
    ones = 0;
    for (int c = 63; c <= 75; c++) begin
      goto(c);
      ones += int'(clk_out[3]) + int'(rise_pls[3]);
    end
    check("ch3_ton0_const0", 32'(ones), 32'h0);
    goto(76); write(3, 0, 4, 0);
    goto(77); cfg_wr = 1'b0;
    ones = 0;
    for (int c = 77; c <= 110; c++) begin
      goto(c);
      ones += int'(rise_pls[3]);
    end
    check("ch3_toff0_one_rise", 32'(ones), 32'h1);
    check("ch3_toff0_const1", 32'(clk_out[3]), 32'h1);

    // Asynchronous reset between edges.
    goto(114); write(2, 2, 2, 2);
    goto(115); cfg_wr = 1'b0;
    check("pre_rst_pend", 32'(cfg_pend[2]), 32'h1);
    check("pre_rst_ch3_high", 32'(clk_out[3]), 32'h1);
    rst = 1'b1;
    #1;
    check("async_rst_clk_out", 32'(clk_out), 32'h0);
    check("async_rst_rise", 32'(rise_pls), 32'h0);
    check("async_rst_pend", 32'(cfg_pend), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    en = 4'b1111; rst = 1'b0; cyc = 0;
    goto(1); check("defaults_all_high", 32'(clk_out), 32'hf);
             check("defaults_all_rise", 32'(rise_pls), 32'hf);
    goto(2); check("defaults_all_low", 32'(clk_out), 32'h0);
    goto(3); check("defaults_all_high2", 32'(clk_out), 32'hf);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      tick();
      cfg_wr = ($urandom_range(0, 4) == 0);
      cfg_ch = 2'($urandom_range(0, 3));
      cfg_phase = rnd_cnt(); cfg_ton = rnd_cnt(); cfg_toff = rnd_cnt();
      for (int b = 0; b < NCh; b++) begin
        if ($urandom_range(0, 24) == 0) en[b] = ~en[b];
      end
      if ($urandom_range(0, 799) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        check("rnd_rst_clk_out", 32'(clk_out), 32'h0);
        @(posedge clk);
        #3;
        rst = 1'b0; cyc = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_clkgen.md
MULTI_CLKGEN -- requirements
Module: multi_clkgen

Interface
REQ-001 Parameter NCH, 4, number of independent output clock channels (1..16).
REQ-002 Parameter CNT_W, 8, width of phase/ton/toff counts in reference-clock cycles.
REQ-003 clk  input  1  reference clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  NCH  per-channel run enable, level-sensitive.
REQ-006 cfg_wr  input  1  one-cycle configuration write strobe.
REQ-007 cfg_ch  input  $clog2(NCH) (min 1)  target channel of the write.
REQ-008 cfg_phase  input  CNT_W  start delay in cycles.
REQ-009 cfg_ton  input  CNT_W  high time in cycles.
REQ-010 cfg_toff  input  CNT_W  low time in cycles.
REQ-011 clk_out  output  NCH  generated clocks, registered.
REQ-012 rise_pls  output  NCH  one-cycle pulse in the cycle clk_out[i] rises.
REQ-013 cfg_pend  output  NCH  shadow config written but not yet applied.

Function
REQ-014 Each channel SHALL hold a shadow (phase, ton, toff) and an active set; cfg_wr writes the shadow of cfg_ch and sets cfg_pend[cfg_ch].
REQ-015 cfg_wr with cfg_ch >= NCH SHALL be ignored.
REQ-016 Channel FSM states: IDLE, PHASE, HIGH, LOW.
REQ-017 IDLE: clk_out=0; shadow copied to active every cycle, cfg_pend cleared.
REQ-018 IDLE with en[i]=1 at edge k: edge k+1 enters PHASE with down-count phase, or HIGH directly if phase=0.
REQ-019 PHASE: clk_out=0 for exactly phase cycles, then HIGH.
REQ-020 HIGH: clk_out=1 for exactly ton cycles, then LOW; LOW: clk_out=0 for exactly toff cycles, then HIGH; period ton+toff.
REQ-021 Every entry into HIGH SHALL copy shadow to active if cfg_pend[i] (glitch-free retune at period boundary) and clear cfg_pend[i]; phase is used only on IDLE exit.
REQ-022 ton=0 with toff>0: clk_out held 0, no rise_pls; toff=0 with ton>0: clk_out held 1 after one rise_pls; both 0: held 0.
REQ-023 en[i] deasserted in any state SHALL force IDLE and clk_out[i]=0 on the next edge; re-enable restarts with phase.
REQ-024 cfg_wr and a HIGH entry on the same edge for the same channel: new value goes to shadow, old shadow applied, cfg_pend stays 1.
REQ-025 Counters SHALL use CNT_W bits; max count 2^CNT_W-1 without wrap.
REQ-026 Channels SHALL be mutually independent; outputs have no combinational path from inputs.

Reset
REQ-027 rst=1 SHALL asynchronously force all channels IDLE, clk_out=0, rise_pls=0, cfg_pend=0, counters 0.
REQ-028 Reset values of shadow/active: phase=0, ton=1, toff=1 (divide-by-2 default).
REQ-029 Reset mid-period SHALL truncate the output immediately without glitch beyond the reset assertion itself.

Structure
REQ-030 Package multi_clkgen_pkg SHALL hold the state enum and default config constants.
REQ-031 One sub-module clkgen_chan (one FSM + counter + shadow) SHALL be instantiated NCH times via generate.

Verification
REQ-032 Reset defaults, en[0]=1 -> clk_out[0] toggles every cycle from cycle 1, rise_pls every 2nd cycle.
REQ-033 ch1 phase=7, ton=5, toff=5, en rises cycle 10 -> first rise cycle 18, period 10, duty 50%.
REQ-034 ch2 running ton=3,toff=2; write ton=1,toff=4 mid-HIGH -> current HIGH stays 3 cycles, new shape from next rise, cfg_pend clears there.
REQ-035 en deasserted mid-HIGH -> clk_out 0 next cycle; re-enable repeats phase delay.
REQ-036 ton=0,toff=4 -> constant 0; ton=4,toff=0 -> constant 1, single rise_pls.
REQ-037 rst pulsed asynchronously between edges while running -> all outputs 0 immediately, defaults restored.
